// File: rtl/sc_regbank.sv
// Register bank: fixed constant register 0 plus REGBANK_DEPTH-1 writable registers, two combinational read ports.
// Writes and clears commit on the falling edge; reads have zero latency; there is no backpressure.
module sc_regbank #(
    parameter int                       DATAWIDTH_BUS      = 32,
    parameter int                       REGBANK_DEPTH      = 32,
    parameter int                       ADDRWIDTH          = 5,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT = '0
) (
    input  logic                     SC_RegBANK_CLOCK_50,
    input  logic                     SC_RegGENERAL_RESET_InHigh,
    input  logic                     SC_RegBANK_Clear_InHigh,
    input  logic                     SC_RegBANK_WriteEnable_InHigh,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_WriteAddr_In,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUS_In,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_ReadAddrA_In,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_ReadAddrB_In,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSA_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSB_Out,
    output logic                     SC_RegBANK_WriteErr_Out
);

    logic [DATAWIDTH_BUS-1:0] r_bank [1:REGBANK_DEPTH-1];
    logic                     r_write_err;
    logic                     w_wr_legal;

    // A write is legal only when its address hits one of the stored registers.
    always_comb begin
        w_wr_legal = 1'b0;
        for (int i = 1; i < REGBANK_DEPTH; i++) begin
            if (SC_RegBANK_WriteAddr_In == ADDRWIDTH'(i)) begin
                w_wr_legal = 1'b1;
            end
        end
    end

    always_ff @(negedge SC_RegBANK_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            for (int i = 1; i < REGBANK_DEPTH; i++) begin
                r_bank[i] <= '0;
            end
            r_write_err <= 1'b0;
        end else if (SC_RegBANK_Clear_InHigh) begin
            for (int i = 1; i < REGBANK_DEPTH; i++) begin
                r_bank[i] <= '0;
            end
            r_write_err <= 1'b0;
        end else if (SC_RegBANK_WriteEnable_InHigh && w_wr_legal) begin
            for (int i = 1; i < REGBANK_DEPTH; i++) begin
                if (SC_RegBANK_WriteAddr_In == ADDRWIDTH'(i)) begin
                    r_bank[i] <= SC_RegBANK_DataBUS_In;
                end
            end
            r_write_err <= 1'b0;
        end else begin
            // Only an illegal write can reach here with the strobe high.
            r_write_err <= SC_RegBANK_WriteEnable_InHigh;
        end
    end

    // Out-of-range addresses match nothing and fall through to zero.
    always_comb begin
        SC_RegBANK_DataBUSA_Out = '0;
        if (SC_RegBANK_ReadAddrA_In == '0) begin
            SC_RegBANK_DataBUSA_Out = DATA_REGFIXED_INIT;
        end
        for (int i = 1; i < REGBANK_DEPTH; i++) begin
            if (SC_RegBANK_ReadAddrA_In == ADDRWIDTH'(i)) begin
                SC_RegBANK_DataBUSA_Out = r_bank[i];
            end
        end
    end

    always_comb begin
        SC_RegBANK_DataBUSB_Out = '0;
        if (SC_RegBANK_ReadAddrB_In == '0) begin
            SC_RegBANK_DataBUSB_Out = DATA_REGFIXED_INIT;
        end
        for (int i = 1; i < REGBANK_DEPTH; i++) begin
            if (SC_RegBANK_ReadAddrB_In == ADDRWIDTH'(i)) begin
                SC_RegBANK_DataBUSB_Out = r_bank[i];
            end
        end
    end

    assign SC_RegBANK_WriteErr_Out = r_write_err;

endmodule

// File: tb/tb_sc_regbank.sv
// Directed bench for sc_regbank: a full-depth bank and a 24-entry bank share the same stimulus.
module tb_sc_regbank;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] da;
    logic [31:0] db;
    logic        werr;
    logic [31:0] da24;
    logic [31:0] db24;
    logic        werr24;

    int checks   = 0;
    int failures = 0;

    sc_regbank #(
        .DATAWIDTH_BUS(32), .REGBANK_DEPTH(32), .ADDRWIDTH(5),
        .DATA_REGFIXED_INIT(32'hCAFE0000)
    ) dut (
        .SC_RegBANK_CLOCK_50          (clk),
        .SC_RegGENERAL_RESET_InHigh   (rst),
        .SC_RegBANK_Clear_InHigh      (clr),
        .SC_RegBANK_WriteEnable_InHigh(we),
        .SC_RegBANK_WriteAddr_In      (waddr),
        .SC_RegBANK_DataBUS_In        (wdata),
        .SC_RegBANK_ReadAddrA_In      (ra),
        .SC_RegBANK_ReadAddrB_In      (rb),
        .SC_RegBANK_DataBUSA_Out      (da),
        .SC_RegBANK_DataBUSB_Out      (db),
        .SC_RegBANK_WriteErr_Out      (werr)
    );

    sc_regbank #(
        .DATAWIDTH_BUS(32), .REGBANK_DEPTH(24), .ADDRWIDTH(5),
        .DATA_REGFIXED_INIT(32'hCAFE0000)
    ) dut24 (
        .SC_RegBANK_CLOCK_50          (clk),
        .SC_RegGENERAL_RESET_InHigh   (rst),
        .SC_RegBANK_Clear_InHigh      (clr),
        .SC_RegBANK_WriteEnable_InHigh(we),
        .SC_RegBANK_WriteAddr_In      (waddr),
        .SC_RegBANK_DataBUS_In        (wdata),
        .SC_RegBANK_ReadAddrA_In      (ra),
        .SC_RegBANK_ReadAddrB_In      (rb),
        .SC_RegBANK_DataBUSA_Out      (da24),
        .SC_RegBANK_DataBUSB_Out      (db24),
        .SC_RegBANK_WriteErr_Out      (werr24)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next falling edge; inputs driven afterwards are stable for the following edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ra = '0; rb = '0;
        #2;
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a); rb = 5'(31 - a);
            #1;
            chk("rst_readA", da, (a == 0) ? 32'hCAFE0000 : 32'h0);
            chk("rst_readB", db, (a == 31) ? 32'hCAFE0000 : 32'h0);
        end
        chk("rst_werr", {31'b0, werr}, 32'h0);
        tick();
        rst = 1'b0;

        // Write to address 5: old value before the edge, new value after.
        we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; ra = 5'd5; rb = 5'd5;
        #1;
        chk("wr5_before_A", da, 32'h0);
        tick();
        we = 1'b0;
        chk("wr5_after_A", da, 32'h12345678);
        chk("wr5_after_B", db, 32'h12345678);
        chk("wr5_werr", {31'b0, werr}, 32'h0);

        // Write to fixed register 0 is rejected with a one-cycle error pulse.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ra = 5'd0;
        tick();
        we = 1'b0;
        chk("wr0_readA", da, 32'hCAFE0000);
        chk("wr0_werr_hi", {31'b0, werr}, 32'h1);
        tick();
        chk("wr0_werr_lo", {31'b0, werr}, 32'h0);

        // Address 30 is out of range only for the 24-deep bank.
        we = 1'b1; waddr = 5'd30; wdata = 32'hDEADBEEF; ra = 5'd30; rb = 5'd23;
        tick();
        we = 1'b0;
        chk("oor30_werr24", {31'b0, werr24}, 32'h1);
        chk("oor30_read24", da24, 32'h0);
        chk("oor30_last24", db24, 32'h0);
        chk("oor30_werr32", {31'b0, werr}, 32'h0);
        chk("oor30_read32", da, 32'hDEADBEEF);
        tick();
        chk("oor30_werr24_lo", {31'b0, werr24}, 32'h0);

        // Boundary of the 24-deep bank: 23 is legal, 24 is not.
        we = 1'b1; waddr = 5'd23; wdata = 32'h00000023;
        tick();
        chk("b23_werr24", {31'b0, werr24}, 32'h0);
        chk("b23_read24", db24, 32'h00000023);
        waddr = 5'd24; wdata = 32'h00000024; ra = 5'd24;
        tick();
        we = 1'b0;
        chk("b24_werr24", {31'b0, werr24}, 32'h1);
        chk("b24_read24", da24, 32'h0);

        // Back-to-back writes: the last edge wins.
        we = 1'b1; waddr = 5'd9; wdata = 32'h1; ra = 5'd9;
        tick();
        wdata = 32'h2;
        tick();
        we = 1'b0;
        chk("b2b_read", da, 32'h2);

        // Fill 1..31 with their own index.
        we = 1'b1;
        for (int a = 1; a < 32; a++) begin
            waddr = 5'(a); wdata = 32'(a);
            tick();
        end
        we = 1'b0;
        ra = 5'd3; rb = 5'd31;
        #1;
        chk("fill_read3", da, 32'd3);
        chk("fill_read31", db, 32'd31);

        // Clear wins over a simultaneous write.
        clr = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
        tick();
        clr = 1'b0; we = 1'b0;
        for (int a = 1; a < 32; a++) begin
            ra = 5'(a);
            #1;
            chk("clr_read", da, 32'h0);
        end
        chk("clr_werr", {31'b0, werr}, 32'h0);

        // Clear with an illegal write raises no error.
        clr = 1'b1; we = 1'b1; waddr = 5'd0; wdata = 32'h5;
        tick();
        clr = 1'b0; we = 1'b0;
        chk("clr_wr0_werr", {31'b0, werr}, 32'h0);

        // Reset between edges forces state immediately; a coincident write is lost.
        we = 1'b1; waddr = 5'd7; wdata = 32'h55; ra = 5'd7;
        tick();
        we = 1'b0;
        chk("wr7_read", da, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_read7", da, 32'h0);
        we = 1'b1; wdata = 32'h66;
        tick();
        chk("rst_edge_read7", da, 32'h0);
        rst = 1'b0; wdata = 32'h77;
        tick();
        we = 1'b0;
        chk("post_rst_read7", da, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
